// File: rtl/irq_pkg.sv
// Shared types and constants for the interrupt aggregation stage.
package irq_pkg;

  localparam logic [31:0] IRQ_VEC_EXT  = 32'h0001_0800;
  localparam logic [31:0] IRQ_VEC_TMR  = 32'h0000_0080;
  localparam logic [31:0] IRQ_VEC_NONE = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE,
    FIRE,
    SERVICE
  } irq_state_t;

  typedef enum logic {
    SRC_EXT,
    SRC_TMR
  } irq_src_t;

  // Request encoding presented to the datapath for a granted source.
  function automatic logic [31:0] src_vec(input irq_src_t src);
    return (src == SRC_EXT) ? IRQ_VEC_EXT : IRQ_VEC_TMR;
  endfunction

endpackage

// File: rtl/irq_if.sv
// Signal bundle between interrupt sources / datapath CSR unit and irq_ctrl.
interface irq_if #(
  parameter int width = 32
);
  logic             timer_tick;
  logic             uart_tx_irq;
  logic             uart_rx_irq;
  logic             mstatus_mie;
  logic             mie_mtie;
  logic             mie_meie;
  logic             irq_ack;
  logic             is_mret;
  logic [width-1:0] irq_vec;
  logic [1:0]       irq_pending;
  logic             in_service;
  logic [7:0]       tmr_overrun;

  modport master (
    output timer_tick, uart_tx_irq, uart_rx_irq, mstatus_mie, mie_mtie, mie_meie,
    output irq_ack, is_mret,
    input  irq_vec, irq_pending, in_service, tmr_overrun
  );

  modport slave (
    input  timer_tick, uart_tx_irq, uart_rx_irq, mstatus_mie, mie_mtie, mie_meie,
    input  irq_ack, is_mret,
    output irq_vec, irq_pending, in_service, tmr_overrun
  );
endinterface

// File: rtl/irq_edge_detect.sv
// Rising-edge detector for a level source. The first cycle after reset only
// loads the history register, so a level already high at reset release is
// not reported as an edge.
module irq_edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic level_i,
  output logic rise_o
);

  logic prev_q;
  logic armed_q;

  // Track the previous level and arm once the history is valid.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_q  <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      prev_q  <= level_i;
      armed_q <= 1'b1;
    end
  end

  assign rise_o = armed_q & level_i & ~prev_q;

endmodule

// File: rtl/irq_ctrl.sv
// Interrupt aggregation: pending latches for the UART edge and timer tick,
// saturating timer overrun counter, and a one-at-a-time request FSM.
//
// state   | meaning
// IDLE    | no request outstanding, waiting for an eligible pending source
// FIRE    | irq_vec driven for the granted source, waiting for irq_ack
// SERVICE | handler running, waiting for mret
module irq_ctrl
  import irq_pkg::*;
#(
  parameter int width = 32
) (
  input logic  clk,
  input logic  reset,
  irq_if.slave bus
);

  logic ext_level;
  logic ext_rise;

  assign ext_level = bus.uart_tx_irq | bus.uart_rx_irq;

  irq_edge_detect u_edge (
    .clk     (clk),
    .reset   (reset),
    .level_i (ext_level),
    .rise_o  (ext_rise)
  );

  irq_state_t       state_q;
  irq_src_t         grant_q;
  irq_src_t         next_src;
  logic [width-1:0] irq_vec_q;
  logic             in_service_q;
  logic             pend_ext_q, pend_ext_d;
  logic             pend_tmr_q, pend_tmr_d;
  logic [7:0]       ovr_q, ovr_d;
  logic             want_ext, want_tmr, eligible, grant_en;
  logic             ack_take, clr_ext, clr_tmr;

  // Eligibility, grant selection and pending/overrun next-state.
  // A set in the same cycle as an ack-clear keeps the bit set.
  always_comb begin
    want_ext   = pend_ext_q & bus.mie_meie;
    want_tmr   = pend_tmr_q & bus.mie_mtie;
    eligible   = bus.mstatus_mie & (want_ext | want_tmr);
    next_src   = want_ext ? SRC_EXT : SRC_TMR;
    grant_en   = bus.mstatus_mie &
                 ((grant_q == SRC_EXT) ? bus.mie_meie : bus.mie_mtie);
    ack_take   = (state_q == FIRE) & bus.irq_ack;
    clr_ext    = ack_take & (grant_q == SRC_EXT);
    clr_tmr    = ack_take & (grant_q == SRC_TMR);
    pend_ext_d = ext_rise | (pend_ext_q & ~clr_ext);
    pend_tmr_d = bus.timer_tick | (pend_tmr_q & ~clr_tmr);
    ovr_d      = ovr_q;
    if (bus.timer_tick && pend_tmr_q && (ovr_q != 8'hFF)) begin
      ovr_d = ovr_q + 8'd1;
    end
  end

  // Pending bits and timer overrun counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_ext_q <= 1'b0;
      pend_tmr_q <= 1'b0;
      ovr_q      <= 8'd0;
    end else begin
      pend_ext_q <= pend_ext_d;
      pend_tmr_q <= pend_tmr_d;
      ovr_q      <= ovr_d;
    end
  end

  // Request FSM with registered irq_vec and in_service.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      grant_q      <= SRC_EXT;
      irq_vec_q    <= '0;
      in_service_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (eligible) begin
            state_q   <= FIRE;
            grant_q   <= next_src;
            irq_vec_q <= width'(src_vec(next_src));
          end
        end
        FIRE: begin
          if (bus.irq_ack) begin
            state_q      <= SERVICE;
            irq_vec_q    <= width'(IRQ_VEC_NONE);
            in_service_q <= 1'b1;
          end else if (!grant_en) begin
            state_q   <= IDLE;
            irq_vec_q <= width'(IRQ_VEC_NONE);
          end
        end
        SERVICE: begin
          if (bus.is_mret) begin
            state_q      <= IDLE;
            in_service_q <= 1'b0;
          end
        end
        default: begin
          state_q      <= IDLE;
          irq_vec_q    <= '0;
          in_service_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.irq_vec     = irq_vec_q;
  assign bus.irq_pending = {pend_ext_q, pend_tmr_q};
  assign bus.in_service  = in_service_q;
  assign bus.tmr_overrun = ovr_q;

endmodule

// File: tb/tb_irq_ctrl.sv
// Bench for irq_ctrl: behavioural reference checked every cycle plus
// directed scenarios with literal expectations.
module tb_irq_ctrl;

  localparam logic [31:0] V_EXT = 32'h0001_0800;
  localparam logic [31:0] V_TMR = 32'h0000_0080;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  irq_if #(.width(32)) bus ();
  irq_ctrl #(.width(32)) dut (.clk(clk), .reset(reset), .bus(bus));

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Reference model: which sources are pending, whether a request is
  // outstanding and for whom, and whether a handler is running.
  logic [1:0] m_pend;
  int         m_grant;   // 1 = external, 2 = timer
  bit         m_req;
  bit         m_active;
  bit         m_prev;
  bit         m_seen;
  int         m_ovr;

  initial begin : model
    bit lvl, ev_ext, en;
    logic [1:0] clr;
    m_pend = 2'b00; m_grant = 0; m_req = 0; m_active = 0;
    m_prev = 0; m_seen = 0; m_ovr = 0;
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        m_pend = 2'b00; m_grant = 0; m_req = 0; m_active = 0;
        m_prev = 0; m_seen = 0; m_ovr = 0;
      end else begin
        lvl    = bus.uart_tx_irq | bus.uart_rx_irq;
        ev_ext = m_seen && lvl && !m_prev;
        m_prev = lvl;
        m_seen = 1;
        clr    = 2'b00;
        if (m_req) begin
          en = bus.mstatus_mie && ((m_grant == 1) ? bus.mie_meie : bus.mie_mtie);
          if (bus.irq_ack) begin
            if (m_grant == 1) clr = 2'b10; else clr = 2'b01;
            m_req = 0;
            m_active = 1;
          end else if (!en) begin
            m_req = 0;
          end
        end else if (m_active) begin
          if (bus.is_mret) m_active = 0;
        end else if (bus.mstatus_mie) begin
          if (m_pend[1] && bus.mie_meie) begin
            m_req = 1; m_grant = 1;
          end else if (m_pend[0] && bus.mie_mtie) begin
            m_req = 1; m_grant = 2;
          end
        end
        if (bus.timer_tick && m_pend[0] && m_ovr < 255) m_ovr++;
        m_pend = (m_pend & ~clr) | {ev_ext, bus.timer_tick};
      end
    end
  end

  // Compare every output against the model on the falling edge.
  initial begin : compare
    logic [31:0] exp_vec;
    forever begin
      @(negedge clk);
      exp_vec = m_req ? ((m_grant == 1) ? V_EXT : V_TMR) : 32'h0;
      chk("model_vec", bus.irq_vec, exp_vec);
      chk("model_pend", 32'(bus.irq_pending), 32'(m_pend));
      chk("model_svc", 32'(bus.in_service), 32'(m_active));
      chk("model_ovr", 32'(bus.tmr_overrun), 32'(m_ovr));
    end
  end

  task automatic step(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #2;
    end
  endtask

  initial begin : stim
    int req_cnt;
    bit prev_nz;
    bus.timer_tick = 0; bus.uart_tx_irq = 0; bus.uart_rx_irq = 0;
    bus.mstatus_mie = 0; bus.mie_mtie = 0; bus.mie_meie = 0;
    bus.irq_ack = 0; bus.is_mret = 0;
    step(2);
    chk("rst_vec", bus.irq_vec, 32'h0);
    chk("rst_pend", 32'(bus.irq_pending), 32'h0);
    chk("rst_svc", 32'(bus.in_service), 32'h0);
    chk("rst_ovr", 32'(bus.tmr_overrun), 32'h0);
    reset = 0;
    bus.mstatus_mie = 1; bus.mie_mtie = 1; bus.mie_meie = 1;
    step(2);

    // Timer tick: pending after one edge, request after two.
    bus.timer_tick = 1; step(); bus.timer_tick = 0;
    chk("tmr_pend", 32'(bus.irq_pending), 32'h1);
    chk("tmr_vec_1cyc", bus.irq_vec, 32'h0);
    step();
    chk("tmr_vec_2cyc", bus.irq_vec, V_TMR);
    bus.irq_ack = 1; step(); bus.irq_ack = 0;
    chk("tmr_ack_pend", 32'(bus.irq_pending), 32'h0);
    chk("tmr_ack_svc", 32'(bus.in_service), 32'h1);
    chk("tmr_ack_vec", bus.irq_vec, 32'h0);
    bus.is_mret = 1; step(); bus.is_mret = 0;
    chk("tmr_mret_svc", 32'(bus.in_service), 32'h0);
    step();

    // UART level held for 200 cycles: exactly one request.
    bus.uart_rx_irq = 1;
    req_cnt = 0; prev_nz = 0;
    for (int i = 0; i < 200; i++) begin
      step();
      if (bus.irq_vec !== 32'h0 && !prev_nz) req_cnt++;
      prev_nz = (bus.irq_vec !== 32'h0);
    end
    chk("uart_req_count", 32'(req_cnt), 32'd1);
    chk("uart_vec", bus.irq_vec, V_EXT);
    bus.irq_ack = 1; step(); bus.irq_ack = 0;
    bus.is_mret = 1; step(); bus.is_mret = 0;
    bus.uart_rx_irq = 0; step(2);
    bus.uart_rx_irq = 1; step(2);
    chk("uart_rearm_vec", bus.irq_vec, V_EXT);
    bus.irq_ack = 1; step(); bus.irq_ack = 0;
    bus.is_mret = 1; step(); bus.is_mret = 0;
    bus.uart_rx_irq = 0; step();

    // Simultaneous tick and UART edge.
    bus.timer_tick = 1; bus.uart_tx_irq = 1; step(); bus.timer_tick = 0;
    chk("sim_pend", 32'(bus.irq_pending), 32'h3);
    step();
    chk("sim_ext_first", bus.irq_vec, V_EXT);
    bus.irq_ack = 1; step(); bus.irq_ack = 0;
    chk("sim_ack_pend", 32'(bus.irq_pending), 32'h1);
    bus.is_mret = 1; step(); bus.is_mret = 0;
    chk("sim_idle_gap", bus.irq_vec, 32'h0);
    step();
    chk("sim_tmr_next", bus.irq_vec, V_TMR);
    bus.irq_ack = 1; step(); bus.irq_ack = 0;
    bus.is_mret = 1; step(); bus.is_mret = 0;
    bus.uart_tx_irq = 0; step();

    // Overrun with global enable off.
    bus.mstatus_mie = 0;
    for (int i = 0; i < 300; i++) begin
      bus.timer_tick = 1; step(); bus.timer_tick = 0; step();
      if (i == 2) chk("ovr_partial", 32'(bus.tmr_overrun), 32'd2);
    end
    chk("ovr_pend", 32'(bus.irq_pending), 32'h1);
    chk("ovr_sat", 32'(bus.tmr_overrun), 32'd255);
    chk("ovr_no_req", bus.irq_vec, 32'h0);
    bus.mstatus_mie = 1; step();
    chk("ovr_req", bus.irq_vec, V_TMR);
    bus.irq_ack = 1; step(); bus.irq_ack = 0;
    bus.is_mret = 1; step(); bus.is_mret = 0;
    step();

    // Withdraw when the granted enable drops without ack.
    bus.uart_tx_irq = 1; step(2);
    chk("wd_vec", bus.irq_vec, V_EXT);
    bus.mie_meie = 0; step();
    chk("wd_vec_off", bus.irq_vec, 32'h0);
    chk("wd_pend", 32'(bus.irq_pending), 32'h2);
    bus.mie_meie = 1; step();
    chk("wd_reissue", bus.irq_vec, V_EXT);
    bus.irq_ack = 1; step(); bus.irq_ack = 0;

    // Reset in SERVICE with both bits pending.
    bus.timer_tick = 1; step(); bus.timer_tick = 0;
    bus.uart_tx_irq = 0; step();
    bus.uart_tx_irq = 1; step();
    chk("pre_rst_pend", 32'(bus.irq_pending), 32'h3);
    chk("pre_rst_svc", 32'(bus.in_service), 32'h1);
    #1 reset = 1;
    #1;
    chk("async_rst_vec", bus.irq_vec, 32'h0);
    chk("async_rst_pend", 32'(bus.irq_pending), 32'h0);
    chk("async_rst_svc", 32'(bus.in_service), 32'h0);
    chk("async_rst_ovr", 32'(bus.tmr_overrun), 32'h0);
    step(2);
    reset = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("post_rst_no_req", bus.irq_vec, 32'h0);
    end
    chk("post_rst_pend", 32'(bus.irq_pending), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/irq_ctrl.md
# irq_ctrl

Interrupt aggregation stage that feeds the 32-bit interrupt vector into the datapath CSR unit. Collects the periodic timer tick and the UART transmit/receive interrupt levels, latches them as pending, and arbitrates them. Issues one request at a time to the datapath with an acknowledge handshake, and holds off further requests until `mret` retires the handler. Replaces ad-hoc one-shot logic at the core top level, and re-arms the UART source on every new edge instead of firing only once after reset.

## Interface
- `width`, 32, width of the interrupt vector.
- `clk` input 1: core clock, all state on rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `timer_tick` input 1: one-cycle pulse from the timer counter.
- `uart_tx_irq` input 1: UART transmit-done level; may stay high for many cycles.
- `uart_rx_irq` input 1: UART receive-done level; may stay high for many cycles.
- `mstatus_mie` input 1: global machine interrupt enable.
- `mie_mtie` input 1: timer interrupt enable.
- `mie_meie` input 1: external (UART) interrupt enable.
- `irq_ack` input 1: datapath has taken the trap (CSR mepc/mcause written).
- `is_mret` input 1: mret retiring in the datapath.
- `irq_vec` output `width`: request vector to the datapath. Encodings: 32'h0001_0800 external, 32'h0000_0080 timer, 0 none.
- `irq_pending` output 2: {ext, tmr} pending bits.
- `in_service` output 1: a handler is active.
- `tmr_overrun` output 8: saturating count of timer ticks lost while timer was already pending.

## Operation
- External source is `uart_tx_irq | uart_rx_irq`. A rising edge of this OR (current=1, previous=0) sets `pend_ext`. A level held high sets it only once. The source re-arms after the level drops.
- A `timer_tick` pulse sets `pend_tmr`. If `pend_tmr` is already 1, `tmr_overrun` increments instead, saturating at 255.
- Priority: external over timer.
- Eligible request: `mstatus_mie` & ((`pend_ext` & `mie_meie`) | (`pend_tmr` & `mie_mtie`)).
- FSM states and transitions:
  - IDLE:
    - Eligible request → FIRE; latch the granted source; drive the matching `irq_vec`.
    - Otherwise stay in IDLE; `irq_vec`=0.
  - FIRE: `irq_vec` holds the granted encoding.
    - `irq_ack` → SERVICE; `irq_vec`=0; clear the granted pending bit.
    - `mstatus_mie` low, or the granted enable low, without ack → withdraw to IDLE; `irq_vec`=0; pending bit kept.
  - SERVICE: `in_service`=1.
    - `is_mret` → IDLE.
    - All new events still latch as pending.
- `irq_ack` outside FIRE is ignored. `is_mret` outside SERVICE is ignored.
- If a set event and an ack-clear of the same pending bit occur in the same cycle, the set wins and the bit stays 1.
- Timer and external events in the same cycle: both bits set. External is granted first; timer is granted after the mret.
- Reset mid-operation:
  - State → IDLE; pending bits and edge register cleared; counter cleared.
  - A UART level already high at reset release is not treated as an edge; the edge register resets to 0 but is loaded on the first cycle with no set.

## Timing
- Reset values: `irq_vec`=0, `irq_pending`=2'b00, `in_service`=0, `tmr_overrun`=0.
- All outputs are registered.
- Latency:
  - Event at edge E1 → pending visible after E1.
  - FIRE and `irq_vec` visible after E2.
  - Total: 2 cycles from input to request.
- `irq_ack` sampled at edge Ea while in FIRE: `irq_vec`=0 and `in_service`=1 after Ea. The datapath must capture `irq_vec` no later than the ack cycle.
- `is_mret` sampled at Em in SERVICE: IDLE after Em. The earliest next `irq_vec` is after Em+1, so there is a minimum one IDLE cycle between handlers.
- Throughput: at most one trap per handler lifetime; there is no nesting.

## Structure
- Package `irq_pkg`:
  - State enum `irq_state_t` {IDLE, FIRE, SERVICE}.
  - Constants `IRQ_VEC_EXT`=32'h0001_0800, `IRQ_VEC_TMR`=32'h0000_0080, `IRQ_VEC_NONE`=0.
  - Source-select enum {SRC_EXT, SRC_TMR}.
- Sub-module `irq_edge_detect`: registered rising-edge detector with async active-high reset, used for the UART level.
- `irq_ctrl` instantiates it and holds the pending registers, overrun counter and FSM.
- At the core top level, `irq_ctrl.irq_vec` drives the datapath `interuppt` input.

## Test plan
- UART level: with all enables=1, hold `uart_rx_irq` high for 200 cycles → exactly one 32'h0001_0800 request. Ack it, mret, then drop the level and raise it again → a second request.
- Timer tick: with enables=1, pulse `timer_tick` → `irq_vec`=32'h0000_0080 exactly 2 cycles later. Ack → `irq_pending`=2'b00, `in_service`=1.
- Simultaneous events: tick and UART edge in the same cycle → `irq_pending`=2'b11 and external granted first. After ack and mret, the timer request appears one IDLE cycle later.
- Overrun: with `mstatus_mie`=0, 300 ticks → one pending timer bit and `tmr_overrun`=255, with no request. Set `mstatus_mie`=1 → timer request issued.
- Withdraw: drop `mie_meie` while in FIRE with no ack → `irq_vec`=0 next cycle and `irq_pending[1]`=1. Re-enable → request reissued.
- Reset: assert `reset` asynchronously in SERVICE with both bits pending → all outputs 0 immediately; after release, no request while the UART level stays high.
